// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
//   arb_state_t  : arbiter sequencing states
//   PORT_IF/D    : winner identifiers
//   starve_cnt_t : fetch starvation counter type (STARVE_W bits)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int unsigned STARVE_W = 4;
    typedef logic [STARVE_W-1:0] starve_cnt_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between the fetch and data ports.
//   if_req, d_req : pending requests
//   starve_cnt    : consecutive contested fetch losses
//   grant_valid   : at least one requester present
//   grant_id      : PORT_IF or PORT_D (don't-care when grant_valid is low)
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic        if_req,
    input  logic        d_req,
    input  starve_cnt_t starve_cnt,
    output logic        grant_valid,
    output logic        grant_id
);

    localparam starve_cnt_t STARVE_LIM = starve_cnt_t'(STARVE_MAX);

    always_comb begin
        grant_valid = if_req | d_req;
        grant_id    = PORT_D;
        // Data has priority under contention until fetch has lost STARVE_MAX times.
        if (if_req && (!d_req || (starve_cnt == STARVE_LIM))) begin
            grant_id = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing a single-ported 64-bit memory between instruction fetch
// (read-only) and the load/store data port. Each access becomes one memory
// request (held while p_memWait is high); read data and a one-cycle done
// pulse are returned to the winner. All outputs are registered.
//   p_clk, p_reset_l                : clock, async active-low reset
//   p_ifReq/p_ifAddr                : fetch request and word address
//   p_ifData/p_ifDone               : fetch data and completion pulse
//   p_dReq/p_dWrite/p_dAddr/p_dWData: data request, store flag, address, store data
//   p_dRData/p_dDone                : load data and completion pulse
//   p_memReadRequest/p_memWriteRequest/p_memAddress/p_memInputData : to memory
//   p_memOutputData/p_memWait       : from memory
//   p_busy                          : arbiter not idle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic        p_clk,
    input  logic        p_reset_l,
    input  logic        p_ifReq,
    input  logic [63:0] p_ifAddr,
    output logic [63:0] p_ifData,
    output logic        p_ifDone,
    input  logic        p_dReq,
    input  logic        p_dWrite,
    input  logic [63:0] p_dAddr,
    input  logic [63:0] p_dWData,
    output logic [63:0] p_dRData,
    output logic        p_dDone,
    output logic        p_memReadRequest,
    output logic        p_memWriteRequest,
    output logic [63:0] p_memAddress,
    output logic [63:0] p_memInputData,
    input  logic [63:0] p_memOutputData,
    input  logic        p_memWait,
    output logic        p_busy
);

    localparam starve_cnt_t STARVE_LIM = starve_cnt_t'(STARVE_MAX);

    arb_state_t  state_q, state_d;
    starve_cnt_t starve_q, starve_d;
    logic        win_q, win_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] if_data_q, if_data_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_req_q, wr_req_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic        busy_q, busy_d;

    logic        grant_valid;
    logic        grant_id;

    mem_arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_select (
        .if_req      (p_ifReq),
        .d_req       (p_dReq),
        .starve_cnt  (starve_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        win_d     = win_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;
        rd_req_d  = 1'b0;
        wr_req_d  = 1'b0;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    win_d   = grant_id;
                    write_d = (grant_id == PORT_D) && p_dWrite;
                    addr_d  = (grant_id == PORT_D) ? p_dAddr : p_ifAddr;
                    wdata_d = (grant_id == PORT_D) ? p_dWData : '0;
                    // Request lines are registered, so they are raised here to be
                    // visible during the first ISSUE cycle.
                    rd_req_d = !write_d;
                    wr_req_d = write_d;
                    state_d  = ISSUE;
                    if (grant_id == PORT_IF) begin
                        starve_d = '0;
                    end else if (p_ifReq && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + starve_cnt_t'(1);
                    end
                end
            end
            ISSUE: begin
                if (p_memWait) begin
                    rd_req_d = rd_req_q;
                    wr_req_d = wr_req_q;
                end else if (write_q) begin
                    state_d   = DONE;
                    if_done_d = (win_q == PORT_IF);
                    d_done_d  = (win_q == PORT_D);
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (win_q == PORT_IF) begin
                    if_data_d = p_memOutputData;
                    if_done_d = 1'b1;
                end else begin
                    d_rdata_d = p_memOutputData;
                    d_done_d  = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge p_clk or negedge p_reset_l) begin
        if (!p_reset_l) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            win_q     <= PORT_IF;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            win_q     <= win_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
            busy_q    <= busy_d;
        end
    end

    assign p_ifData          = if_data_q;
    assign p_ifDone          = if_done_q;
    assign p_dRData          = d_rdata_q;
    assign p_dDone           = d_done_q;
    assign p_memReadRequest  = rd_req_q;
    assign p_memWriteRequest = wr_req_q;
    assign p_memAddress      = addr_q;
    assign p_memInputData    = wdata_q;
    assign p_busy            = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand
// sequences for contention / wait / reset / dropped request, and random
// transactions checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        p_clk;
    logic        p_reset_l;
    logic        p_ifReq;
    logic [63:0] p_ifAddr;
    logic [63:0] p_ifData;
    logic        p_ifDone;
    logic        p_dReq;
    logic        p_dWrite;
    logic [63:0] p_dAddr;
    logic [63:0] p_dWData;
    logic [63:0] p_dRData;
    logic        p_dDone;
    logic        p_memReadRequest;
    logic        p_memWriteRequest;
    logic [63:0] p_memAddress;
    logic [63:0] p_memInputData;
    logic [63:0] p_memOutputData;
    logic        p_memWait;
    logic        p_busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .p_clk             (p_clk),
        .p_reset_l         (p_reset_l),
        .p_ifReq           (p_ifReq),
        .p_ifAddr          (p_ifAddr),
        .p_ifData          (p_ifData),
        .p_ifDone          (p_ifDone),
        .p_dReq            (p_dReq),
        .p_dWrite          (p_dWrite),
        .p_dAddr           (p_dAddr),
        .p_dWData          (p_dWData),
        .p_dRData          (p_dRData),
        .p_dDone           (p_dDone),
        .p_memReadRequest  (p_memReadRequest),
        .p_memWriteRequest (p_memWriteRequest),
        .p_memAddress      (p_memAddress),
        .p_memInputData    (p_memInputData),
        .p_memOutputData   (p_memOutputData),
        .p_memWait         (p_memWait),
        .p_busy            (p_busy)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    // ---------------- memory model (256 words, low address byte) ----------
    function automatic logic [63:0] pattern(input int i);
        if (i == 16) return 64'hDEAD_BEEF_0000_0001;
        return {32'hC0DE_0000 + 32'(i), 32'h1357_9BDF ^ 32'(i * 40503)};
    endfunction

    logic [63:0] mem [0:255];
    always @(posedge p_clk or negedge p_reset_l) begin
        if (!p_reset_l) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
            p_memOutputData <= 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
            p_memOutputData <= 64'hBAD0_BAD0_BAD0_BAD0;
            if (p_memReadRequest && !p_memWait)
                p_memOutputData <= mem[p_memAddress[7:0]];
            if (p_memWriteRequest && !p_memWait)
                mem[p_memAddress[7:0]] <= p_memInputData;
        end
    end

    // ---------------- reference model state --------------------------------
    logic [63:0] ref_mem [0:255];
    int          m_starve;

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        m_starve = 0;
    endtask

    // Returns 1 for data winner, 0 for fetch winner, and updates the starve count.
    function automatic int model_pick(input logic ir, input logic dr);
        if (ir && dr) begin
            if (m_starve == int'(STARVE_MAX)) begin
                m_starve = 0;
                return 0;
            end
            if (m_starve < int'(STARVE_MAX)) m_starve++;
            return 1;
        end
        if (ir) begin
            m_starve = 0;
            return 0;
        end
        return 1;
    endfunction

    // ---------------- helpers -----------------------------------------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic drive_idle();
        p_ifReq   = 1'b0;
        p_ifAddr  = '0;
        p_dReq    = 1'b0;
        p_dWrite  = 1'b0;
        p_dAddr   = '0;
        p_dWData  = '0;
        p_memWait = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   64'(p_busy), 64'd0);
        check({tag, "_rdreq"},  64'(p_memReadRequest), 64'd0);
        check({tag, "_wrreq"},  64'(p_memWriteRequest), 64'd0);
        check({tag, "_maddr"},  p_memAddress, 64'd0);
        check({tag, "_mdata"},  p_memInputData, 64'd0);
        check({tag, "_ifdata"}, p_ifData, 64'd0);
        check({tag, "_ifdone"}, 64'(p_ifDone), 64'd0);
        check({tag, "_drdata"}, p_dRData, 64'd0);
        check({tag, "_ddone"},  64'(p_dDone), 64'd0);
    endtask

    task automatic do_reset();
        drive_idle();
        p_reset_l = 1'b0;
        repeat (2) tick();
        p_reset_l = 1'b1;
        tick();
        ref_init();
    endtask

    // Presents one request set in an IDLE cycle (cycle 0), holds p_memWait high
    // for `waits` cycles from cycle 1, and reports the first completion.
    // Returns with the arbiter back in IDLE and no request pending.
    task automatic run_txn(input logic ir, input logic dr, input logic dw,
                           input logic [63:0] ia, input logic [63:0] da,
                           input logic [63:0] wd, input int waits,
                           output int win, output int cyc, output logic [63:0] data,
                           output int reqcyc, output logic [1:0] kind,
                           output logic [63:0] first_addr, output logic stable);
        p_ifReq = ir; p_ifAddr = ia;
        p_dReq = dr; p_dWrite = dw; p_dAddr = da; p_dWData = wd;
        p_memWait = 1'b0;
        win = -1; cyc = -1; data = '0; reqcyc = 0; kind = 2'b00;
        first_addr = '0; stable = 1'b1;
        for (int c = 1; c <= 30 && win < 0; c++) begin
            tick();
            p_memWait = (c <= waits);
            if (p_memReadRequest || p_memWriteRequest) begin
                reqcyc++;
                if (reqcyc == 1) begin
                    first_addr = p_memAddress;
                    kind = {p_memWriteRequest, p_memReadRequest};
                end else if (p_memAddress !== first_addr ||
                             {p_memWriteRequest, p_memReadRequest} !== kind) begin
                    stable = 1'b0;
                end
            end
            if (p_ifDone || p_dDone) begin
                win  = (p_ifDone && p_dDone) ? 2 : (p_dDone ? 1 : 0);
                cyc  = c;
                data = p_dDone ? p_dRData : p_ifData;
                p_ifReq = 1'b0;
                p_dReq  = 1'b0;
                p_memWait = 1'b0;
            end
        end
        drive_idle();
        tick();
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        string       name;
        logic        ir;
        logic        dr;
        logic        dw;
        logic [63:0] ia;
        logic [63:0] da;
        logic [63:0] wd;
        int          waits;
        int          exp_win;
        int          exp_cyc;
        logic [63:0] exp_addr;
        logic        chk_data;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    int          win, cyc, reqcyc;
    logic [63:0] data, faddr;
    logic [1:0]  kind;
    logic        stable;

    task automatic check_txn(input string nm, input int ew, input int ec,
                             input logic ewr, input int waits, input logic [63:0] ea,
                             input logic cd, input logic [63:0] ed);
        check({nm, "_winner"}, 64'(win), 64'(ew));
        check({nm, "_cycle"},  64'(cyc), 64'(ec));
        check({nm, "_reqcyc"}, 64'(reqcyc), 64'(waits + 1));
        check({nm, "_kind"},   64'(kind), ewr ? 64'd2 : 64'd1);
        check({nm, "_addr"},   faddr, ea);
        check({nm, "_stable"}, 64'(stable), 64'd1);
        if (cd) check({nm, "_data"}, data, ed);
    endtask

    initial begin
        int exp_order[10];
        int order[10];
        int dcyc[10];
        int n;
        int cnt_a, cnt_b, cnt_c, cnt_d, done_c;

        p_reset_l = 1'b0;
        drive_idle();

        vecs[0] = '{"fetch_alone", 1, 0, 0, 64'h10, 64'h0, 64'h0, 0, 0, 3, 64'h10, 1, 64'hDEAD_BEEF_0000_0001};
        vecs[1] = '{"store_20", 0, 1, 1, 64'h0, 64'h20, 64'h1234, 0, 1, 2, 64'h20, 0, 64'h0};
        vecs[2] = '{"load_20", 0, 1, 0, 64'h0, 64'h20, 64'h0, 0, 1, 3, 64'h20, 1, 64'h1234};
        vecs[3] = '{"fetch_wait3", 1, 0, 0, 64'h10, 64'h0, 64'h0, 3, 0, 6, 64'h10, 1, 64'hDEAD_BEEF_0000_0001};
        vecs[4] = '{"store_wait2", 0, 1, 1, 64'h0, 64'h30, 64'hCAFE, 2, 1, 4, 64'h30, 0, 64'h0};
        vecs[5] = '{"load_wait1", 0, 1, 0, 64'h0, 64'h30, 64'h0, 1, 1, 4, 64'h30, 1, 64'hCAFE};
        vecs[6] = '{"both_d_wins", 1, 1, 0, 64'h10, 64'h20, 64'h0, 0, 1, 3, 64'h20, 1, 64'h1234};
        vecs[7] = '{"fetch_wide", 1, 0, 1, 64'hFFFF_FFFF_FFFF_FF10, 64'h0, 64'h0, 0, 0, 3,
                    64'hFFFF_FFFF_FFFF_FF10, 1, 64'hDEAD_BEEF_0000_0001};
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset state
        repeat (2) tick();
        check_zero("reset");
        p_reset_l = 1'b1;
        tick();
        ref_init();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].ia, vecs[i].da, vecs[i].wd,
                    vecs[i].waits, win, cyc, data, reqcyc, kind, faddr, stable);
            check_txn(vecs[i].name, vecs[i].exp_win, vecs[i].exp_cyc,
                      vecs[i].dr && vecs[i].dw && vecs[i].exp_win == 1, vecs[i].waits,
                      vecs[i].exp_addr, vecs[i].chk_data, vecs[i].exp_data);
        end

        // Contention: both requests held, loads, starve count starts at 0.
        n = 0;
        p_ifReq = 1'b1; p_ifAddr = 64'h10;
        p_dReq = 1'b1; p_dWrite = 1'b0; p_dAddr = 64'h20;
        for (int c = 1; c <= 80 && n < 10; c++) begin
            tick();
            if (p_ifDone || p_dDone) begin
                order[n] = p_dDone ? 1 : 0;
                dcyc[n]  = c;
                if (p_dDone) check("cont_ddata", p_dRData, 64'h1234);
                else         check("cont_ifdata", p_ifData, 64'hDEAD_BEEF_0000_0001);
                n++;
                if (n == 10) drive_idle();
            end
        end
        drive_idle();
        tick();
        check("cont_count", 64'(n), 64'd10);
        for (int i = 0; i < n; i++) begin
            check("cont_order", 64'(order[i]), 64'(exp_order[i]));
            if (i > 0) check("cont_period", 64'(dcyc[i] - dcyc[i-1]), 64'd4);
        end

        // Reset during RESP of a data load, with starve count built up to 3.
        for (int i = 0; i < 3; i++) begin
            run_txn(1, 1, 0, 64'h10, 64'h20, 64'h0, 0, win, cyc, data, reqcyc, kind, faddr, stable);
            check("prerst_winner", 64'(win), 64'd1);
        end
        p_dReq = 1'b1; p_dWrite = 1'b0; p_dAddr = 64'h20;
        tick();
        tick();
        check("prerst_busy", 64'(p_busy), 64'd1);
        #1 p_reset_l = 1'b0;
        #1;
        check_zero("midrst");
        drive_idle();
        done_c = 0;
        repeat (2) begin
            tick();
            if (p_dDone || p_ifDone) done_c++;
        end
        p_reset_l = 1'b1;
        repeat (5) begin
            tick();
            if (p_dDone || p_ifDone) done_c++;
        end
        check("midrst_no_done", 64'(done_c), 64'd0);
        ref_init();
        for (int i = 0; i < 5; i++) begin
            run_txn(1, 1, 0, 64'h10, 64'h20, 64'h0, 0, win, cyc, data, reqcyc, kind, faddr, stable);
            check("postrst_winner", 64'(win), (i == 4) ? 64'd0 : 64'd1);
        end
        run_txn(1, 0, 0, 64'h10, 64'h0, 64'h0, 0, win, cyc, data, reqcyc, kind, faddr, stable);
        check_txn("postrst_fetch", 0, 3, 1'b0, 0, 64'h10, 1'b1, 64'hDEAD_BEEF_0000_0001);

        // Data request pulsed for one cycle while fetch is in ISSUE.
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; done_c = -1;
        p_ifReq = 1'b1; p_ifAddr = 64'h10;
        for (int c = 1; c <= 14; c++) begin
            tick();
            p_memWait = (c <= 2);
            p_dReq    = (c == 1);
            p_dWrite  = 1'b1;
            p_dAddr   = 64'h55;
            p_dWData  = 64'h5555;
            if (p_memWriteRequest) cnt_a++;
            if ((p_memReadRequest || p_memWriteRequest) && p_memAddress !== 64'h10) cnt_d++;
            if (p_dDone) cnt_b++;
            if (p_ifDone) begin
                cnt_c++;
                done_c = c;
                p_ifReq = 1'b0;
            end
        end
        drive_idle();
        tick();
        check("drop_wrreq", 64'(cnt_a), 64'd0);
        check("drop_otheraddr", 64'(cnt_d), 64'd0);
        check("drop_ddone", 64'(cnt_b), 64'd0);
        check("drop_ifdone", 64'(cnt_c), 64'd1);
        check("drop_ifcycle", 64'(done_c), 64'd5);

        // Random transactions against the reference model.
        do_reset();
        for (int t = 0; t < 150; t++) begin
            logic        ir, dr, dw, ewr;
            logic [63:0] ia, da, wd, ea, ed;
            int          w, ew;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) begin
                ir = 1'b1;
                dr = 1'($urandom_range(0, 1));
            end
            dw = 1'($urandom_range(0, 1));
            ia = {$urandom, ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(8'h40, 8'h47))};
            da = {$urandom, ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(8'h40, 8'h47))};
            wd = {$urandom, $urandom};
            w  = $urandom_range(0, 3);

            ew  = model_pick(ir, dr);
            ewr = (ew == 1) && dw;
            ea  = (ew == 1) ? da : ia;
            ed  = ref_mem[ea[7:0]];
            if (ewr) ref_mem[ea[7:0]] = wd;

            run_txn(ir, dr, dw, ia, da, wd, w, win, cyc, data, reqcyc, kind, faddr, stable);
            check_txn("rand", ew, (ewr ? 2 : 3) + w, ewr, w, ea, !ewr, ed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
